// File: rtl/barrett_reduce_pipe_if.sv
// Stream bundle for the Barrett reducer: operand side and result side.
// The reducer takes the slave view; the producer/consumer takes master.
interface barrett_reduce_pipe_if #(
   parameter int IN_W  = 24,
   parameter int K     = 12,
   parameter int TAG_W = 4
) ();
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             in_neg;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [K-1:0]     out_data;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_data, in_neg, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_neg, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett reducer: a mod Q (optionally negated) with tag
// sideband, one operand per cycle, full backpressure via a shared enable.
module barrett_reduce_pipe #(
   parameter int Q     = 3373,
   parameter int K     = 12,
   parameter int IN_W  = 2*K,
   parameter int TAG_W = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   barrett_reduce_pipe_if.slave bus
);

   localparam logic [63:0] MU64 = (64'd1 << (2*K)) / 64'(Q);
   localparam logic [K:0]   MU  = MU64[K:0];
   localparam logic [K-1:0] QK  = K'(Q);
   localparam logic [K+1:0] Q1  = (K+2)'(Q);
   localparam logic [K+1:0] Q2  = (K+2)'(2*Q);
   localparam logic [K+1:0] Q3  = (K+2)'(3*Q);

   if (Q <= 2**(K-1) || Q >= 2**K || IN_W > 2*K || TAG_W < 1)
   begin : g_bad_param
      $error("barrett_reduce_pipe: illegal Q/K/IN_W/TAG_W");
   end

   logic             en;
   logic [2*K-1:0]   a_ext;
   logic [K:0]       t1h_d;
   logic [K+1:0]     diff_d;
   logic             ge1, ge2, ge3;
   logic [K-1:0]     r_d;
   logic [K-1:0]     out_d;

   logic             v1_q, neg1_q;
   logic [K+1:0]     a1_q;
   logic [K:0]       t1h_q;
   logic [TAG_W-1:0] tag1_q;
   logic             v2_q, neg2_q;
   logic [K+1:0]     diff_q;
   logic [TAG_W-1:0] tag2_q;
   logic             ov_q;
   logic [K-1:0]     od_q;
   logic [TAG_W-1:0] ot_q;

   assign en           = bus.out_ready | ~ov_q;
   assign bus.in_ready = en;
   assign bus.out_valid = ov_q;
   assign bus.out_data  = od_q;
   assign bus.out_tag   = ot_q;

   // t1 can exceed 2^(2K) when Q is near 2^(K-1); keep the extra bit.
   assign a_ext = (2*K)'(bus.in_data);
   assign t1h_d = (K+1)'(
      ({{(K+1){1'b0}}, a_ext[2*K-1:K]} * {{K{1'b0}}, MU}) >> K);

   // Only the low K+2 bits matter: the true difference is below 4Q.
   assign diff_d = a1_q - ((K+2)'(t1h_q) * (K+2)'(QK));

   assign ge1 = diff_q >= Q1;
   assign ge2 = diff_q >= Q2;
   assign ge3 = diff_q >= Q3;

   always_comb begin
      r_d = '0;
      unique case (1'b1)
         ge3:         r_d = K'(diff_q - Q3);
         ge2 && !ge3: r_d = K'(diff_q - Q2);
         ge1 && !ge2: r_d = K'(diff_q - Q1);
         !ge1:        r_d = K'(diff_q);
      endcase
   end

   assign out_d = (neg2_q && r_d != '0) ? QK - r_d : r_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         a1_q   <= '0;
         t1h_q  <= '0;
         neg1_q <= 1'b0;
         tag1_q <= '0;
         v2_q   <= 1'b0;
         diff_q <= '0;
         neg2_q <= 1'b0;
         tag2_q <= '0;
         ov_q   <= 1'b0;
         od_q   <= '0;
         ot_q   <= '0;
      end else if (en) begin
         v1_q <= bus.in_valid;
         if (bus.in_valid) begin
            a1_q   <= a_ext[K+1:0];
            t1h_q  <= t1h_d;
            neg1_q <= bus.in_neg;
            tag1_q <= bus.in_tag;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            diff_q <= diff_d;
            neg2_q <= neg1_q;
            tag2_q <= tag1_q;
         end
         ov_q <= v2_q;
         if (v2_q) begin
            od_q <= out_d;
            ot_q <= tag2_q;
         end
      end
   end

endmodule
